// File: rtl/imem_loader.sv
// imem_loader: streams a word-count header plus big-endian payload bytes into
// the byte-wide instruction memory, holding the fetch stage in reset until the
// final byte write has been launched.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] HDR_HI = 3'd1;
   localparam logic [2:0] HDR_LO = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] ERR    = 3'd5;

   // Largest legal word count: exactly fills the memory.
   localparam logic [16:0] CAPACITY = 17'd1 << (ADDR_W - 2);

   logic [2:0]  state;
   logic [7:0]  n_hi;
   logic [15:0] n_words;
   logic [17:0] byte_cnt;
   logic        accept;
   logic [16:0] n_full;
   logic        last_byte;

   assign accept    = in_valid && in_ready;
   // Word count as it will be once the low header byte is latched.
   assign n_full    = {1'b0, n_hi, in_data};
   // Counter is wide enough that 4*N never overflows for any 16-bit N.
   assign last_byte = (byte_cnt == ({n_words, 2'b00} - 18'd1));

   // Ready decode: bytes are only taken while a load is in progress.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         HDR_HI:  in_ready = 1'b1;
         HDR_LO:  in_ready = 1'b1;
         DATA:    in_ready = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Loader FSM, header capture, byte counter and registered memory write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         n_hi      <= 8'd0;
         n_words   <= 16'd0;
         byte_cnt  <= 18'd0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         cpu_hold  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= HDR_HI;
                  busy  <= 1'b1;
               end
            end
            HDR_HI: begin
               if (accept) begin
                  n_hi  <= in_data;
                  state <= HDR_LO;
               end
            end
            HDR_LO: begin
               if (accept) begin
                  n_words  <= n_full[15:0];
                  byte_cnt <= 18'd0;
                  if (n_full == 17'd0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     busy     <= 1'b0;
                  end else if (n_full > CAPACITY) begin
                     state <= ERR;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               // start is deliberately ignored here; the load runs to completion.
               if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= byte_cnt[ADDR_W-1:0];
                  mem_wdata <= in_data;
                  byte_cnt  <= byte_cnt + 18'd1;
                  if (last_byte) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     busy     <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  state    <= HDR_HI;
                  done     <= 1'b0;
                  cpu_hold <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ERR: begin
               if (start) begin
                  state <= HDR_HI;
                  err   <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               cpu_hold <= 1'b1;
               busy     <= 1'b0;
               done     <= 1'b0;
               err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (ADDR_W=10). A monitor checks
// write timing every cycle and logs writes; loads are compared to the stream.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       mem_we;
   logic [9:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   logic        payload = 1'b0;
   logic        mon_en  = 1'b0;
   logic        mon_acc;
   logic [17:0] wq [$];
   logic [7:0]  stream [$];

   imem_loader #(.ADDR_W(10)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each payload accept must give exactly one mem_we pulse in the next cycle.
   always @(posedge clk) begin
      mon_acc = in_valid && in_ready && payload;
      #1;
      if (mon_en) begin
         check("we_timing", {31'd0, mem_we}, {31'd0, mon_acc});
         if (mem_we) wq.push_back({mem_addr, mem_wdata});
      end
   end

   // Called at a negedge; start is seen on the following posedge.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles; returns at the negedge after it is accepted.
   task automatic send(input logic [7:0] b, input int gap, input logic pay);
      int t;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      payload  = pay;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic load_stream(input logic use_gaps, input int start_at);
      wq.delete();
      for (int i = 0; i < stream.size(); i++) begin
         if (i == start_at) start = 1'b1;
         send(stream[i], use_gaps ? (i % 3) : 0, (i >= 2) ? 1'b1 : 1'b0);
         start = 1'b0;
      end
      in_valid = 1'b0;
      payload  = 1'b0;
   endtask

   task automatic compare_writes(input int exp_cnt);
      check("wr_count", wq.size(), exp_cnt);
      for (int i = 0; i < wq.size() && i < exp_cnt; i++) begin
         check("wr_addr", {22'd0, wq[i][17:8]}, i);
         check("wr_data", {24'd0, wq[i][7:0]}, {24'd0, stream[i+2]});
      end
   endtask

   task automatic set_basic();
      logic [7:0] b [10];
      b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      stream.delete();
      for (int i = 0; i < 10; i++) stream.push_back(b[i]);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #23;
      check("rst_hold",  {31'd0, cpu_hold}, 32'd1);
      check("rst_busy",  {31'd0, busy},     32'd0);
      check("rst_done",  {31'd0, done},     32'd0);
      check("rst_err",   {31'd0, err},      32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_we",    {31'd0, mem_we},   32'd0);
      check("rst_addr",  {22'd0, mem_addr}, 32'd0);
      check("rst_wdata", {24'd0, mem_wdata},32'd0);
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Basic back-to-back load.
      set_basic();
      pulse_start();
      check("start_busy",  {31'd0, busy},     32'd1);
      check("start_ready", {31'd0, in_ready}, 32'd1);
      load_stream(1'b0, -1);
      check("basic_done", {31'd0, done},     32'd1);
      check("basic_hold", {31'd0, cpu_hold}, 32'd0);
      check("basic_busy", {31'd0, busy},     32'd0);
      check("basic_lastwe", {31'd0, mem_we}, 32'd1);
      compare_writes(8);
      @(negedge clk);

      // Same stream with gaps.
      pulse_start();
      check("restart_done", {31'd0, done},     32'd0);
      check("restart_hold", {31'd0, cpu_hold}, 32'd1);
      load_stream(1'b1, -1);
      check("gap_done", {31'd0, done}, 32'd1);
      compare_writes(8);
      @(negedge clk);

      // Zero words.
      stream.delete(); stream.push_back(8'h00); stream.push_back(8'h00);
      pulse_start();
      load_stream(1'b0, -1);
      check("zero_done", {31'd0, done},     32'd1);
      check("zero_hold", {31'd0, cpu_hold}, 32'd0);
      repeat (2) @(negedge clk);
      compare_writes(0);

      // Over capacity: N=257.
      stream.delete(); stream.push_back(8'h01); stream.push_back(8'h01);
      pulse_start();
      load_stream(1'b0, -1);
      check("cap_err",   {31'd0, err},      32'd1);
      check("cap_hold",  {31'd0, cpu_hold}, 32'd1);
      check("cap_ready", {31'd0, in_ready}, 32'd0);
      check("cap_done",  {31'd0, done},     32'd0);
      check("cap_busy",  {31'd0, busy},     32'd0);
      repeat (2) @(negedge clk);
      compare_writes(0);

      // Recovery from ERR, with a start pulse landing on a DATA accept.
      set_basic();
      pulse_start();
      check("recover_err", {31'd0, err}, 32'd0);
      load_stream(1'b0, 6);
      check("ign_done", {31'd0, done}, 32'd1);
      check("ign_err",  {31'd0, err},  32'd0);
      compare_writes(8);
      @(negedge clk);

      // Exact capacity: N=256 -> 1024 writes ending at 0x3FF.
      stream.delete(); stream.push_back(8'h01); stream.push_back(8'h00);
      for (int i = 0; i < 1024; i++) stream.push_back(8'((i * 37 + 11) ^ (i >> 8)));
      pulse_start();
      load_stream(1'b0, -1);
      check("full_done", {31'd0, done}, 32'd1);
      check("full_last", {22'd0, mem_addr}, 32'h3FF);
      compare_writes(1024);
      @(negedge clk);

      // Asynchronous reset in the middle of DATA with in_valid held high.
      set_basic();
      pulse_start();
      for (int i = 0; i < 5; i++) send(stream[i], 0, (i >= 2) ? 1'b1 : 1'b0);
      mon_en = 1'b0;
      payload = 1'b0;
      in_valid = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("mid_rst_hold",  {31'd0, cpu_hold}, 32'd1);
      check("mid_rst_busy",  {31'd0, busy},     32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_we",    {31'd0, mem_we},   32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_ready", {31'd0, in_ready}, 32'd0);
         check("post_rst_we",    {31'd0, mem_we},   32'd0);
         check("post_rst_hold",  {31'd0, cpu_hold}, 32'd1);
      end
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
